// File: rtl/instr_feeder.sv
// Byte-stream instruction assembler: pairs bytes into 16-bit words, drops unimplemented
// opcodes, and buffers accepted words in a first-word-fall-through FIFO for the core.
module instr_feeder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          s_tvalid,
   output logic          s_tready,
   input  logic [7:0]    s_tdata,
   output logic          m_tvalid,
   input  logic          m_tready,
   output logic [15:0]   m_tdata,
   output logic [CW-1:0] level,
   output logic [7:0]    drop_cnt,
   output logic          byte_phase
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {StLo, StHi} state_e;

   state_e        state_q, state_d;
   logic [7:0]    hold_q, hold_d;
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] level_q, level_d;
   logic [7:0]    drop_q, drop_d;
   logic          byte_acc;
   logic          push;
   logic          pop;
   logic [15:0]   word;

   // Ready depends on registered level only, so no path from m_tready to s_tready.
   assign s_tready   = (level_q != CW'(DEPTH));
   assign m_tvalid   = (level_q != '0);
   assign m_tdata    = mem_q[rd_ptr_q];
   assign level      = level_q;
   assign drop_cnt   = drop_q;
   assign byte_phase = (state_q == StHi);

   assign byte_acc = s_tvalid & s_tready;
   assign pop      = m_tvalid & m_tready;
   assign word     = {s_tdata, hold_q};

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      drop_d  = drop_q;
      push    = 1'b0;
      case (state_q)
         StLo: begin
            if (byte_acc) begin
               hold_d  = s_tdata;
               state_d = StHi;
            end
         end
         StHi: begin
            if (byte_acc) begin
               state_d = StLo;
               // Only opcodes 0..3 are implemented by the core.
               if (word[3:2] == 2'b00) begin
                  push = 1'b1;
               end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
         end
         default: state_d = StLo;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= StLo;
         hold_q   <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
      end
   end

   // Storage is cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 16'h0000;
      end else if (push) begin
         mem_q[wr_ptr_q] <= word;
      end
   end

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: directed scenarios plus randomized traffic
// compared against a queue-based model of the word stream.
module tb_instr_feeder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rstn;
   logic          s_tvalid;
   logic          s_tready;
   logic [7:0]    s_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic [15:0]   m_tdata;
   logic [CW-1:0] level;
   logic [7:0]    drop_cnt;
   logic          byte_phase;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0] m_q[$];
   logic [15:0] exp_out[$];
   logic [15:0] act_out[$];
   int          m_drop;
   logic        m_phase;
   logic [7:0]  m_hold;

   instr_feeder #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .s_tdata    (s_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tdata    (m_tdata),
      .level      (level),
      .drop_cnt   (drop_cnt),
      .byte_phase (byte_phase)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Advance one clock, updating the model from the inputs presented this cycle.
   task automatic cycle();
      logic        acc;
      logic        pp;
      logic [15:0] w;
      if (!rstn) begin
         m_q.delete();
         m_drop  = 0;
         m_phase = 1'b0;
         m_hold  = 8'h00;
      end else begin
         pp  = (m_q.size() > 0) && m_tready;
         acc = s_tvalid && (m_q.size() < int'(DEPTH));
         if (m_tvalid && m_tready) act_out.push_back(m_tdata);
         if (pp) exp_out.push_back(m_q.pop_front());
         if (acc) begin
            if (!m_phase) begin
               m_hold = s_tdata;
            end else begin
               w = {s_tdata, m_hold};
               if (w[3:0] < 4'd4) m_q.push_back(w);
               else if (m_drop < 255) m_drop++;
            end
            m_phase = ~m_phase;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      s_tvalid = 1'b1;
      s_tdata  = b;
      while (m_q.size() >= int'(DEPTH) && n < 100) begin
         cycle();
         n++;
      end
      if (n == 100) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout: got stalled expected accept of %h", b);
      end
      cycle();
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      m_tready = 1'b1;
      while (m_q.size() > 0 && n < 100) begin
         cycle();
         n++;
      end
      m_tready = 1'b0;
      if (n == 100) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got level %0d expected 0", level);
      end
   endtask

   function automatic logic [15:0] rand_valid_word();
      logic [15:0] w;
      w = 16'($urandom);
      w[3:0] = 4'($urandom_range(0, 3));
      return w;
   endfunction

   task automatic test_reset();
      rstn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = 8'h00;
      cycle();
      cycle();
      rstn = 1'b1;
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %b expected 1", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
      checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
      checks++; if (byte_phase !== 1'b0) begin errors++; $display("FAIL reset_phase: got %b expected 0", byte_phase); end
      checks++; if (m_tdata !== 16'h0000) begin errors++; $display("FAIL reset_m_tdata: got %h expected 0000", m_tdata); end
   endtask

   task automatic test_single_word();
      act_out.delete();
      m_tready = 1'b0;
      send_byte(8'h10);
      checks++; if (byte_phase !== 1'b1) begin errors++; $display("FAIL single_phase: got %b expected 1", byte_phase); end
      send_byte(8'h0C);
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", m_tvalid); end
      checks++; if (m_tdata !== 16'h0C10) begin errors++; $display("FAIL single_data: got %h expected 0c10", m_tdata); end
      checks++; if (level !== CW'(1)) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
      m_tready = 1'b1;
      cycle();
      m_tready = 1'b0;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", m_tvalid); end
      checks++; if (level !== '0) begin errors++; $display("FAIL single_pop_level: got %0d expected 0", level); end
      checks++;
      if (act_out.size() != 1 || act_out[0] !== 16'h0C10) begin
         errors++; $display("FAIL single_popped: got %0d words expected one 0c10", act_out.size());
      end
   endtask

   task automatic test_filter();
      logic [7:0] lo;
      send_byte(8'h37);
      send_byte(8'h12);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL filter_valid: got %b expected 0", m_tvalid); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL filter_drop1: got %0d expected 1", drop_cnt); end
      for (int i = 0; i < 300; i++) begin
         lo = {4'($urandom), 4'($urandom_range(4, 15))};
         send_byte(lo);
         send_byte(8'($urandom));
      end
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL filter_saturate: got %0d expected 255", drop_cnt); end
      checks++; if (level !== '0) begin errors++; $display("FAIL filter_level: got %0d expected 0", level); end
   endtask

   task automatic test_full();
      logic [15:0] w[5];
      act_out.delete();
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) w[i] = rand_valid_word();
      for (int i = 0; i < 4; i++) begin
         send_byte(w[i][7:0]);
         send_byte(w[i][15:8]);
      end
      checks++; if (level !== CW'(4)) begin errors++; $display("FAIL full_level: got %0d expected 4", level); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", s_tready); end
      s_tvalid = 1'b1;
      s_tdata  = w[4][7:0];
      cycle();
      cycle();
      checks++; if (byte_phase !== 1'b0) begin errors++; $display("FAIL full_stall_phase: got %b expected 0", byte_phase); end
      checks++; if (m_tdata !== w[0]) begin errors++; $display("FAIL full_head_stable: got %h expected %h", m_tdata, w[0]); end
      m_tready = 1'b1;
      cycle();
      m_tready = 1'b0;
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL full_release_ready: got %b expected 1", s_tready); end
      checks++; if (level !== CW'(3)) begin errors++; $display("FAIL full_release_level: got %0d expected 3", level); end
      send_byte(w[4][7:0]);
      send_byte(w[4][15:8]);
      drain();
      checks++;
      if (act_out.size() != 5) begin
         errors++; $display("FAIL full_count: got %0d expected 5", act_out.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (act_out[i] !== w[i]) begin
               errors++; $display("FAIL full_order[%0d]: got %h expected %h", i, act_out[i], w[i]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [15:0] w[20];
      int over = 0;
      act_out.delete();
      m_tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         w[i] = rand_valid_word();
         send_byte(w[i][7:0]);
         if (level > CW'(1)) over++;
         m_tready = 1'b1;
         send_byte(w[i][15:8]);
         if (level > CW'(1)) over++;
      end
      checks++; if (over != 0) begin errors++; $display("FAIL wrap_level: got %0d cycles above 1 expected 0", over); end
      drain();
      checks++;
      if (act_out.size() != 20) begin
         errors++; $display("FAIL wrap_count: got %0d expected 20", act_out.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            checks++;
            if (act_out[i] !== w[i]) begin
               errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, act_out[i], w[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_word();
      act_out.delete();
      m_tready = 1'b0;
      send_byte(8'hAA);
      checks++; if (byte_phase !== 1'b1) begin errors++; $display("FAIL midrst_phase_hi: got %b expected 1", byte_phase); end
      rstn = 1'b0;
      cycle();
      rstn = 1'b1;
      checks++; if (byte_phase !== 1'b0) begin errors++; $display("FAIL midrst_phase_lo: got %b expected 0", byte_phase); end
      send_byte(8'h01);
      send_byte(8'h00);
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL midrst_valid: got %b expected 1", m_tvalid); end
      checks++; if (m_tdata !== 16'h0001) begin errors++; $display("FAIL midrst_data: got %h expected 0001", m_tdata); end
      drain();
      checks++;
      if (act_out.size() != 1 || act_out[0] !== 16'h0001) begin
         errors++; $display("FAIL midrst_output: got %0d words expected one 0001", act_out.size());
      end
   endtask

   task automatic test_random();
      act_out.delete();
      exp_out.delete();
      for (int c = 0; c < 600; c++) begin
         s_tvalid = ($urandom_range(0, 3) != 0);
         s_tdata  = 8'($urandom);
         if (!m_phase) s_tdata[3:0] = 4'($urandom_range(0, 7));
         m_tready = ($urandom_range(0, 5) == 0);
         cycle();
         checks++;
         if (level !== CW'(m_q.size()) || s_tready !== (m_q.size() < int'(DEPTH)) ||
             m_tvalid !== (m_q.size() > 0) || byte_phase !== m_phase ||
             drop_cnt !== 8'(m_drop)) begin
            errors++;
            $display("FAIL rand_state@%0d: got lvl=%0d rdy=%b vld=%b ph=%b drop=%0d expected lvl=%0d ph=%b drop=%0d",
                     c, level, s_tready, m_tvalid, byte_phase, drop_cnt, m_q.size(), m_phase, m_drop);
         end
         if (m_q.size() > 0) begin
            checks++;
            if (m_tdata !== m_q[0]) begin
               errors++; $display("FAIL rand_head@%0d: got %h expected %h", c, m_tdata, m_q[0]);
            end
         end
      end
      s_tvalid = 1'b0;
      drain();
      checks++;
      if (act_out.size() != exp_out.size()) begin
         errors++; $display("FAIL rand_count: got %0d expected %0d", act_out.size(), exp_out.size());
      end else begin
         for (int i = 0; i < act_out.size(); i++) begin
            checks++;
            if (act_out[i] !== exp_out[i]) begin
               errors++; $display("FAIL rand_order[%0d]: got %h expected %h", i, act_out[i], exp_out[i]);
            end
         end
      end
   endtask

   initial begin
      rstn = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
      m_drop = 0; m_phase = 1'b0; m_hold = 8'h00;
      @(posedge clk);
      #1;
      test_reset();
      test_single_word();
      test_filter();
      test_reset();
      test_full();
      test_wrap();
      test_reset_mid_word();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Upstream stage of the CPU FSM core. Receives instructions as a byte stream, assembles each pair of bytes into a 16-bit instruction word, and discards words whose opcode the core does not implement. Buffers accepted words in a small FIFO and presents them to the core's slave stream port (valid/ready/data), one word per handshake.

## Interface

**Parameters**
- `DEPTH`, default 4: FIFO depth in words. Power of two, ≥2.
- `CW`, default $clog2(DEPTH)+1: width of `level`.

**Ports**
- `clk` in 1: clock; all logic on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `s_tvalid` in 1: input byte valid.
- `s_tready` out 1: input byte accepted this cycle when `s_tvalid & s_tready`.
- `s_tdata` in 8: input byte; low byte of a word first, then high byte.
- `m_tvalid` out 1: instruction available to the core.
- `m_tready` in 1: core accepts the word.
- `m_tdata` out 16: instruction word. [3:0] opcode, [9:4] opA, [15:10] opB.
- `level` out CW: number of words held in the FIFO, 0..DEPTH.
- `drop_cnt` out 8: count of discarded words, saturating at 255.
- `byte_phase` out 1: 0 = expecting low byte, 1 = expecting high byte.

## Operation

- **Reset** (rstn=0 at an edge): `level`=0, `m_tvalid`=0, `drop_cnt`=0, `byte_phase`=0, FIFO pointers=0, low-byte holding register=0. `s_tready` is 1 after reset.
  - `m_tdata` is don't-care while `m_tvalid`=0; it drives 16'h0000 after reset.
  - Reset asserted mid-word discards the held low byte.
- **Assembler FSM**, 2 states:
  - LO: on an accepted byte, store it in the holding register and go to HI.
  - HI: on an accepted byte, form the word {s_tdata, hold} and go to LO.
  - No timeout: HI waits indefinitely.
- **Opcode filter**, applied when a word forms:
  - Opcode in 0..3: write the word to the FIFO tail.
  - Opcode 4..15: do not write it; increment `drop_cnt` (saturating; stays at 255).
- **`s_tready` rule:** `s_tready` = (`level` != DEPTH), from registered state only. No combinational path from `m_tready`.
  - In LO, bytes are accepted under the same rule, so a new word cannot start while the FIFO is full.
- **FIFO:** first-word-fall-through.
  - `m_tvalid` = (`level` != 0).
  - `m_tdata` = word at the head; stable while `m_tvalid=1` and `m_tready=0`.
  - A pop occurs on `m_tvalid & m_tready`.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- **Simultaneous push and pop** in one cycle: `level` unchanged, both pointers advance.
  - Push while full is impossible by the `s_tready` rule.
  - Pop while empty is impossible by the `m_tvalid` rule.
  - `m_tready` while `m_tvalid=0` is ignored.

## Timing

- **Latency:** high byte accepted at edge N → word visible (`m_tvalid=1`, `m_tdata` valid) after edge N, provided the FIFO was empty. Minimum byte-to-output latency is 1 cycle.
- **Throughput:** one byte per cycle on input, so at most one word every 2 cycles. Output is one word per cycle when the FIFO holds data.
- `level`, `drop_cnt` and `byte_phase` update at the same edge as the event that changes them.
- **Full → not-full:** a pop at edge N raises `s_tready` after edge N. There is no same-cycle fall-through from a pop to `s_tready`.
- The downstream core holds `m_tready` high only in its IDLE state, so words are consumed at most once every 6 cycles. The FIFO absorbs the rate mismatch.

## Test plan

1. **Reset state:** reset → `s_tready=1`, `m_tvalid=0`, `level=0`, `drop_cnt=0`, `byte_phase=0`.
2. **Single word:** bytes 8'h10 then 8'h0C with `m_tready=0` → after the second byte, `m_tvalid=1`, `m_tdata=16'h0C10` (opcode 0, opA 1, opB 3), `level=1`. Raise `m_tready` for one cycle → `m_tvalid=0`, `level=0`.
3. **Opcode filter:** word 16'h1237 (opcode 7) → no push, `m_tvalid` stays 0, `drop_cnt=1`. Send 300 invalid words → `drop_cnt=255`.
4. **Full and back-pressure:** `DEPTH=4`, `m_tready=0`, stream 5 valid words (10 bytes) with `s_tvalid` held high.
   - After 4 words: `level=4` and `s_tready=0`; the 9th byte stalls.
   - Pulse `m_tready` → `s_tready=1` on the next cycle.
   - All 5 words exit in order with no loss.
5. **Wrap and concurrent push/pop:** `m_tready=1` continuously while streaming 20 valid words → output sequence equals input sequence, `level` never exceeds 1, pointers wrap at least 4 times.
6. **Reset mid-word:** send low byte 8'hAA, assert `rstn=0` for one edge, then send bytes 8'h01, 8'h00 → one word 16'h0001 is output. The stale 8'hAA never appears.
